// File: rtl/serial_twos_complementer_n_if.sv
// Serial word stream into and out of the two's-complementer.
// The master drives the input stream; the slave (the complementer) drives the result stream.
interface serial_twos_complementer_n_if;
    logic       in_valid;
    logic       in_sof;
    logic       x;
    logic [1:0] mode;
    logic       z;
    logic       out_valid;
    logic       out_sof;
    logic       out_eof;
    logic       ovf;
    logic       err;

    modport master (
        output in_valid, in_sof, x, mode,
        input  z, out_valid, out_sof, out_eof, ovf, err
    );

    modport slave (
        input  in_valid, in_sof, x, mode,
        output z, out_valid, out_sof, out_eof, ovf, err
    );
endinterface

// File: rtl/serial_twos_complementer_n.sv
// Bit-serial pass / negate / absolute-value unit, LSB first.
// A capture side frames input words; an output shifter emits each result word with registered outputs.
module serial_twos_complementer_n #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           areset,
    serial_twos_complementer_n_if.slave    bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, COPY, INVERT} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [1:0]       mode_q, mode_d;
    logic             neg_q, neg_d;
    logic             ovf_flag_q, ovf_flag_d;
    logic             z_q, z_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eof_q, out_eof_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic             xfer;
    logic             neg_w;
    logic [WIDTH-1:0] word;

    // Capture side: a non-zero count means a word is open.
    always_comb begin
        cnt_d  = cnt_q;
        cap_d  = cap_q;
        mode_d = mode_q;
        err_d  = 1'b0;
        xfer   = 1'b0;
        word   = cap_q;
        word[WIDTH-1] = bus.x;
        if (bus.in_valid) begin
            if (bus.in_sof) begin
                err_d    = (cnt_q != '0);
                mode_d   = bus.mode;
                cap_d[0] = bus.x;
                cnt_d    = CW'(1);
            end else if (cnt_q != '0) begin
                cap_d[cnt_q] = bus.x;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    xfer  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
        neg_w = (mode_q == 2'b01) || ((mode_q == 2'b10) && bus.x);
    end

    // Outputs are registered, so the state register holds the state that applies to
    // the next bit: bit 0 is emitted in COPY at the transfer edge itself.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        rem_d       = rem_q;
        neg_d       = neg_q;
        ovf_flag_d  = ovf_flag_q;
        z_d         = 1'b0;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        ovf_d       = 1'b0;
        if (xfer) begin
            sh_d        = word >> 1;
            rem_d       = CW'(WIDTH - 1);
            neg_d       = neg_w;
            ovf_flag_d  = neg_w && (word == {1'b1, {(WIDTH-1){1'b0}}});
            z_d         = word[0];
            out_valid_d = 1'b1;
            out_sof_d   = 1'b1;
            state_d     = (neg_w && word[0]) ? INVERT : COPY;
        end else if (state_q != IDLE) begin
            z_d         = (state_q == INVERT) ? ~sh_q[0] : sh_q[0];
            out_valid_d = 1'b1;
            sh_d        = sh_q >> 1;
            rem_d       = rem_q - CW'(1);
            if (rem_q == CW'(1)) begin
                out_eof_d = 1'b1;
                ovf_d     = ovf_flag_q;
                state_d   = IDLE;
            end else if ((state_q == COPY) && neg_q && sh_q[0]) begin
                state_d = INVERT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            cap_q       <= '0;
            sh_q        <= '0;
            mode_q      <= '0;
            neg_q       <= 1'b0;
            ovf_flag_q  <= 1'b0;
            z_q         <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            cap_q       <= cap_d;
            sh_q        <= sh_d;
            mode_q      <= mode_d;
            neg_q       <= neg_d;
            ovf_flag_q  <= ovf_flag_d;
            z_q         <= z_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign bus.z         = z_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;
endmodule

// File: doc/serial_twos_complementer_n.md
SERIAL_TWOS_COMPLEMENTER_N -- requirements
Module: serial_twos_complementer_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, serial word length in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port areset, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: x and in_sof are meaningful this cycle.
REQ-005 SHALL have port in_sof, input, 1: the current valid bit is bit 0 (LSB) of a new word.
REQ-006 SHALL have port x, input, 1: serial data, LSB first.
REQ-007 SHALL have port mode, input, 2: 00 pass, 01 negate, 10 absolute value, 11 reserved (treated as pass); sampled only with in_valid && in_sof.
REQ-008 SHALL have port z, output, 1: serial result, LSB first.
REQ-009 SHALL have port out_valid, output, 1: z is a result bit this cycle.
REQ-010 SHALL have port out_sof, output, 1: z is bit 0 of a result word.
REQ-011 SHALL have port out_eof, output, 1: z is bit WIDTH-1 of a result word.
REQ-012 SHALL have port ovf, output, 1: asserted with out_eof when negate/abs was applied to the most-negative value.
REQ-013 SHALL have port err, output, 1: one-cycle pulse on a framing error.

Function
REQ-014 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-015 Capture: on in_valid && in_sof the block SHALL latch mode, store x as bit 0 and set the bit count to 1.
REQ-016 Capture: each later in_valid && !in_sof bit SHALL be stored at the bit-count position, then the count SHALL increment.
REQ-017 Capture: in_valid low SHALL hold the count and stored bits; gaps of any length are legal.
REQ-018 Bits with in_valid && !in_sof while no word is open SHALL be discarded silently.
REQ-019 in_sof with a word partly captured (count 1..WIDTH-1) SHALL discard the partial word, pulse err the next cycle, and start a new word with the current bit.
REQ-020 When bit WIDTH-1 is accepted at edge k, the word and its mode SHALL transfer to the output shifter at edge k; the capture side SHALL be free for in_sof in the next cycle.
REQ-021 The output SHALL emit bit 0 in the cycle after edge k, then one bit per cycle with out_valid high for exactly WIDTH consecutive cycles; out_sof SHALL be set on the first and out_eof on the last.
REQ-022 No backpressure: input cannot exceed 1 bit/cycle, so the shifter always finishes before the next transfer; a back-to-back next word SHALL give out_valid continuously high.
REQ-023 The output FSM SHALL have states IDLE, COPY and INVERT.
REQ-024 IDLE->COPY on transfer.
REQ-025 In COPY, z = stored bit; a 1 bit SHALL move COPY->INVERT after that bit, when negation is active.
REQ-026 In INVERT, z = ~stored bit.
REQ-027 After the last bit the FSM SHALL go to IDLE, or to COPY if a transfer occurs that cycle.
REQ-028 Negation active SHALL mean: mode 01; or mode 10 with stored bit WIDTH-1 = 1. Otherwise the FSM SHALL stay in COPY (pass-through).
REQ-029 ovf SHALL be 1 with out_eof iff negation was active and the stored word is 1 followed by WIDTH-1 zeros; that output equals the input.
REQ-030 When out_valid is low, z, out_sof, out_eof and ovf SHALL be 0.

Reset
REQ-031 areset high at a rising edge SHALL set the FSM to IDLE, bit count to 0, no word open, and z, out_valid, out_sof, out_eof, ovf, err all to 0 from the next cycle.
REQ-032 areset SHALL override all inputs that cycle.
REQ-033 areset mid-capture or mid-output SHALL abandon the word with no further output bits; the first in_sof after reset release SHALL start cleanly.

Verification (WIDTH=4, bits listed LSB first)
REQ-034 Negate 3: mode=01, in 1,1,0,0 contiguous -> z 1,0,1,1 starting the cycle after the 4th bit; out_sof on bit 0, out_eof on bit 3, ovf=0.
REQ-035 Abs of -6: mode=10, in 0,1,0,1 with in_valid gaps -> z 0,1,1,0; abs of +5 (in 1,0,1,0) -> z 1,0,1,0 unchanged.
REQ-036 Most-negative: mode=01, in 0,0,0,1 -> z 0,0,0,1, ovf=1 with out_eof; mode=00 same input -> ovf=0.
REQ-037 Back-to-back: two words, in_sof every 4th cycle -> out_valid high 8 consecutive cycles, each word using its own latched mode.
REQ-038 Framing: in_sof after 2 bits -> err pulse one cycle; only the restarted word is output; stray valid bits before any in_sof produce no output.
REQ-039 Reset mid-output: areset during output bit 2 -> all outputs 0 next cycle; the following word is processed correctly.
